// File: rtl/sseg_display_scheduler.sv
// Four-digit seven-segment scan driver: picks score (BCD via double dabble),
// raw guess nibbles, or a perimeter chase animation, and drives anodes/cathodes.
module sseg_display_scheduler #(
    parameter int REFRESH_DIV = 50000,
    parameter int ANIM_DIV    = 12500000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        disp_score,
    input  logic        sseg_mode,
    input  logic [13:0] score,
    input  logic [15:0] guess,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);
    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int AW = (ANIM_DIV > 2) ? $clog2(ANIM_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

    logic [RW-1:0] r_ref_cnt;
    logic [1:0]    r_digit;
    logic [AW-1:0] r_anim_cnt;
    logic [3:0]    r_step;
    logic          r_mode_d;
    state_t        r_state, w_state_nxt;
    logic [29:0]   r_work;
    logic [13:0]   r_sample, r_last;
    logic [3:0]    r_bitcnt;
    logic [15:0]   r_bcd;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;

    logic [13:0]   w_sat;
    logic          w_start, w_rise;
    logic [29:0]   w_adj;
    logic [3:0]    w_step_eff;
    logic [1:0]    w_owner;
    logic [2:0]    w_segidx;
    logic [3:0]    w_bcd_nib, w_guess_nib;
    logic          w_lead;
    logic [6:0]    w_seg_nxt;

    function automatic logic [6:0] f_glyph(input logic [3:0] n);
        case (n)
            4'd0: f_glyph = 7'b1000000;
            4'd1: f_glyph = 7'b1111001;
            4'd2: f_glyph = 7'b0100100;
            4'd3: f_glyph = 7'b0110000;
            4'd4: f_glyph = 7'b0011001;
            4'd5: f_glyph = 7'b0010010;
            4'd6: f_glyph = 7'b0000010;
            4'd7: f_glyph = 7'b1111000;
            4'd8: f_glyph = 7'b0000000;
            4'd9: f_glyph = 7'b0010000;
            default: f_glyph = 7'b1111111;
        endcase
    endfunction

    // Scan and animation timing
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ref_cnt  <= '0;
            r_digit    <= 2'd0;
            r_anim_cnt <= '0;
            r_step     <= 4'd0;
            r_mode_d   <= 1'b0;
        end else begin
            r_mode_d <= sseg_mode;
            if (r_ref_cnt == RW'(REFRESH_DIV - 1)) begin
                r_ref_cnt <= '0;
                r_digit   <= r_digit + 2'd1;
            end else begin
                r_ref_cnt <= r_ref_cnt + RW'(1);
            end
            if (w_rise) begin
                r_anim_cnt <= '0;
                r_step     <= 4'd0;
            end else if (r_anim_cnt == AW'(ANIM_DIV - 1)) begin
                r_anim_cnt <= '0;
                r_step     <= (r_step == 4'd11) ? 4'd0 : r_step + 4'd1;
            end else begin
                r_anim_cnt <= r_anim_cnt + AW'(1);
            end
        end
    end

    assign w_rise = sseg_mode & ~r_mode_d;
    assign w_sat   = (score > 14'd9999) ? 14'd9999 : score;
    assign w_start = (w_sat != r_last);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_bitcnt == 4'd13) w_state_nxt = S_LATCH;
            S_LATCH: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Add-3 on any BCD nibble >= 5 before each shift
    always_comb begin
        w_adj = r_work;
        for (int i = 0; i < 4; i++) begin
            if (r_work[14 + 4*i +: 4] >= 4'd5)
                w_adj[14 + 4*i +: 4] = r_work[14 + 4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_work   <= '0;
            r_sample <= '0;
            r_last   <= '0;
            r_bitcnt <= 4'd0;
            r_bcd    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_sample <= w_sat;
                    r_work   <= {16'd0, w_sat};
                    r_bitcnt <= 4'd0;
                end
                S_SHIFT: begin
                    r_work   <= w_adj << 1;
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
                S_LATCH: begin
                    r_bcd  <= r_work[29:14];
                    r_last <= r_sample;
                end
                default: ;
            endcase
        end
    end

    // A rising sseg_mode shows step 0 on the very cycle it is seen
    assign w_step_eff = w_rise ? 4'd0 : r_step;

    always_comb begin
        w_owner  = 2'd3;
        w_segidx = 3'd0;
        case (w_step_eff)
            4'd0:  begin w_owner = 2'd3; w_segidx = 3'd0; end
            4'd1:  begin w_owner = 2'd2; w_segidx = 3'd0; end
            4'd2:  begin w_owner = 2'd1; w_segidx = 3'd0; end
            4'd3:  begin w_owner = 2'd0; w_segidx = 3'd0; end
            4'd4:  begin w_owner = 2'd0; w_segidx = 3'd1; end
            4'd5:  begin w_owner = 2'd0; w_segidx = 3'd2; end
            4'd6:  begin w_owner = 2'd0; w_segidx = 3'd3; end
            4'd7:  begin w_owner = 2'd1; w_segidx = 3'd3; end
            4'd8:  begin w_owner = 2'd2; w_segidx = 3'd3; end
            4'd9:  begin w_owner = 2'd3; w_segidx = 3'd3; end
            4'd10: begin w_owner = 2'd3; w_segidx = 3'd4; end
            4'd11: begin w_owner = 2'd3; w_segidx = 3'd5; end
            default: ;
        endcase
    end

    assign w_bcd_nib   = r_bcd[{r_digit, 2'b00} +: 4];
    assign w_guess_nib = guess[{r_digit, 2'b00} +: 4];

    always_comb begin
        w_lead = 1'b0;
        case (r_digit)
            2'd3: w_lead = (r_bcd[15:12] == 4'd0);
            2'd2: w_lead = (r_bcd[15:8]  == 8'd0);
            2'd1: w_lead = (r_bcd[15:4]  == 12'd0);
            default: w_lead = 1'b0;
        endcase
    end

    always_comb begin
        w_seg_nxt = 7'b1111111;
        if (sseg_mode) begin
            if (r_digit == w_owner) w_seg_nxt = ~(7'b0000001 << w_segidx);
        end else if (disp_score) begin
            if (!w_lead) w_seg_nxt = f_glyph(w_bcd_nib);
        end else begin
            w_seg_nxt = f_glyph(w_guess_nib);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
        end else begin
            r_an  <= ~(4'b0001 << r_digit);
            r_seg <= w_seg_nxt;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = 1'b1;
endmodule

// File: tb/tb_sseg_display_scheduler.sv
// Directed bench for sseg_display_scheduler with REFRESH_DIV=4, ANIM_DIV=2.
module tb_sseg_display_scheduler;
    localparam int R = 4;
    localparam int D = 2;
    localparam logic [6:0] BL = 7'b1111111;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        disp_score = 1'b0;
    logic        sseg_mode = 1'b0;
    logic [13:0] score = 14'd0;
    logic [15:0] guess = 16'h1234;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int total = 0;
    int bad   = 0;
    int k     = 0;
    int r     = 0;

    sseg_display_scheduler #(.REFRESH_DIV(R), .ANIM_DIV(D)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .disp_score(disp_score), .sseg_mode(sseg_mode),
        .score(score), .guess(guess), .an(an), .seg(seg), .dp(dp)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d: got %b expected %b", tag, k, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        k++;
    endtask

    // Output after edge k shows digit ((k-1)/R)%4, counted from reset release
    task automatic chk_disp(input string tag, input logic [3:0][6:0] pat);
        int d;
        logic [3:0] ea;
        d  = ((k - 1) / R) % 4;
        ea = ~(4'b0001 << d);
        chk({tag, "_an"}, {3'b000, an}, {3'b000, ea});
        chk({tag, "_seg"}, seg, pat[d]);
        chk({tag, "_dp"}, {6'd0, dp}, 7'd1);
    endtask

    function automatic logic [3:0][6:0] anim_pat(input int s);
        logic [3:0][6:0] p;
        p = {4{BL}};
        case (s)
            0:  p[3] = 7'b1111110;
            1:  p[2] = 7'b1111110;
            2:  p[1] = 7'b1111110;
            3:  p[0] = 7'b1111110;
            4:  p[0] = 7'b1111101;
            5:  p[0] = 7'b1111011;
            6:  p[0] = 7'b1110111;
            7:  p[1] = 7'b1110111;
            8:  p[2] = 7'b1110111;
            9:  p[3] = 7'b1110111;
            10: p[3] = 7'b1101111;
            11: p[3] = 7'b1011111;
            default: ;
        endcase
        return p;
    endfunction

    task automatic reset_release();
        @(negedge CLK);
        RESET_N = 1'b1;
        k = 0;
    endtask

    task automatic mid_reset(input string tag);
        #2;
        RESET_N = 1'b0;
        #1;
        chk({tag, "_an"}, {3'b000, an}, 7'b0001111);
        chk({tag, "_seg"}, seg, BL);
        chk({tag, "_dp"}, {6'd0, dp}, 7'd1);
    endtask

    initial begin
        #12;
        chk("por_an", {3'b000, an}, 7'b0001111);
        chk("por_seg", seg, BL);
        reset_release();
        for (int i = 0; i < 6; i++) tick();
        mid_reset("rst_mid");
        reset_release();

        // guess 1234: digit0 '4' .. digit3 '1'
        for (int i = 0; i < 16; i++) begin
            tick();
            chk_disp("guess1234", {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
        end

        guess = 16'hA5F0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk_disp("guessA5F0", {BL, 7'b0010010, BL, 7'b1000000});
        end

        disp_score = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk_disp("score0", {BL, BL, BL, 7'b1000000});
        end

        score = 14'd42;
        for (int i = 0; i < 17; i++) tick();
        for (int i = 0; i < 16; i++) begin
            chk_disp("score42", {BL, BL, 7'b0011001, 7'b0100100});
            tick();
        end

        // 12345 sampled at next edge; 7 arrives mid-conversion
        score = 14'd12345;
        for (int i = 0; i < 3; i++) tick();
        score = 14'd7;
        for (int i = 0; i < 13; i++) tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            chk_disp("sat9999", {4{7'b0010000}});
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            chk_disp("score7", {BL, BL, BL, 7'b1111000});
        end

        // animation from reset, sseg_mode high, disp_score ignored
        @(negedge CLK);
        sseg_mode = 1'b1;
        score = 14'd5;
        mid_reset("rst_anim");
        reset_release();
        r = 1;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk_disp("anim", anim_pat((k == r) ? 0 : ((k - r - 1) / D) % 12));
        end

        // converter ran in the background
        sseg_mode = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk_disp("score5", {BL, BL, BL, 7'b0010010});
        end

        sseg_mode = 1'b1;
        r = k + 1;
        for (int i = 0; i < 26; i++) begin
            tick();
            chk_disp("anim_rise", anim_pat((k == r) ? 0 : ((k - r - 1) / D) % 12));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
